// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizing helpers for the two-master data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_e;

  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic int starve_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Up-counter that saturates at MAX; clear has priority over increment.
module arb_sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value  = cnt_q;
  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: core (m0) has default
// priority, m1 may lock short bursts, and a starvation guard bounds m1's wait.
//
//  state | meaning
//  OWN0  | core owns the port; m1 taken over when core idle or m1 starved
//  OWN1  | m1 owns the port; kept while locked, limited to MAX_BURST beats under core demand
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_BURST  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          owner
);

  localparam int BURST_W  = burst_w(MAX_BURST);
  localparam int STARVE_W = starve_w(STARVE_MAX);

  owner_e owner_q, owner_d;

  logic [BURST_W-1:0]  beat_cnt;
  logic                beat_at_max;
  logic [STARVE_W-1:0] starve_cnt_unused;
  logic                starve_full;
  logic                last_beat;
  logic                beat_clr;

  assign m0_gnt = reset_n & m0_req & (owner_q == OWN0);
  assign m1_gnt = reset_n & m1_req & (owner_q == OWN1);

  // The beat counter saturates at MAX_BURST after long bursts with the core
  // idle; treating saturation as "last beat" keeps the limit enforceable then.
  assign last_beat = beat_at_max | (beat_cnt == BURST_W'(MAX_BURST - 1));
  assign beat_clr  = (owner_q == OWN1) && (owner_d == OWN0);

  arb_sat_counter #(
    .WIDTH (BURST_W),
    .MAX   (MAX_BURST)
  ) u_beat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (m1_gnt),
    .clr     (beat_clr),
    .value   (beat_cnt),
    .at_max  (beat_at_max)
  );

  arb_sat_counter #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (m1_req & ~m1_gnt),
    .clr     (m1_gnt | ~m1_req),
    .value   (starve_cnt_unused),
    .at_max  (starve_full)
  );

  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OWN0: begin
        if (m1_req && (!m0_req || starve_full)) begin
          owner_d = OWN1;
        end
      end
      OWN1: begin
        if (!m1_req || (m0_req && !m1_lock) || (m0_req && m1_gnt && last_beat)) begin
          owner_d = OWN0;
        end
      end
      default: owner_d = OWN0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWN0;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    mem_a  = m0_addr;
    mem_wd = m0_wdata;
    mem_we = m0_we & m0_gnt;
    if (owner_q == OWN1) begin
      mem_a  = m1_addr;
      mem_wd = m1_wdata;
      mem_we = m1_we & m1_gnt;
    end
  end

  assign m0_rdata = mem_rd;
  assign m1_rdata = mem_rd;
  assign owner    = owner_q;

endmodule
